idct_quality_monitor: RTL

Synthesizable checker placed after the approximate IDCT. It buffers the original 8-bit pixels as they enter the DCT. It then frames the IDCT output into 8×8 blocks, extracts and saturates the pixel field, and accumulates per-block and running squared error against the buffered originals. It replaces the bench-side file dump for on-chip and long-run quality measurement, and its totals are used to compute PSNR.

---
 rtl/idct_quality_monitor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/idct_quality_monitor.sv
// rtl/idct_quality_monitor.sv - IDCT output framing and squared-error monitor against buffered originals
module idct_quality_monitor #(
  parameter int BitWidth = 31,
  parameter int PIX_LSB  = 17,
  parameter int FIFO_AW  = 8,
  parameter int BLK      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ref_valid,
  input  logic [7:0]        ref_pix,
  input  logic              idct_done,
  input  logic [BitWidth:0] idct_dout,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic [21:0]       blk_sse,
  output logic              blk_valid,
  output logic [47:0]       tot_sse,
  output logic [23:0]       blk_count,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_short
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BLK + 1);

  typedef enum logic [1:0] {S_WAIT, S_CAP, S_HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          capture, blk_last, short_evt;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   occ;
  logic               fifo_full, fifo_empty, do_push, do_pop;
  logic [7:0]         ref_head;

  logic [7:0]  pix_sat;
  logic        unused_lsbs;
  logic [7:0]  s1_ref;
  logic        s1_first, s1_last;
  logic [7:0]  abs_d;
  logic [15:0] sq_c;
  logic [15:0] s2_sq;
  logic        s2_valid, s2_first, s2_last;
  logic [21:0] blk_acc, acc_sum;

  // occupancy never exceeds DEPTH, so its MSB alone flags a full FIFO
  assign fifo_full  = occ[FIFO_AW];
  assign fifo_empty = (occ == '0);
  assign do_pop     = capture & ~fifo_empty;
  assign do_push    = ref_valid & (~fifo_full | do_pop);
  assign ref_head   = fifo_empty ? 8'd0 : mem[rd_ptr];

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ref_pix;
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (ref_valid && !do_push) err_ovf <= 1'b1;
    end
  end

  // capture FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // capture FSM: frame the done window into BLK-sample blocks (BLK >= 2)
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    blk_last  = 1'b0;
    short_evt = 1'b0;
    case (state)
      S_WAIT: begin
        if (idct_done) begin
          capture  = 1'b1;
          cnt_nx   = CW'(1);
          state_nx = S_CAP;
        end
      end
      S_CAP: begin
        if (idct_done) begin
          capture = 1'b1;
          cnt_nx  = cnt + 1'b1;
          if (cnt_nx == CW'(BLK)) begin
            blk_last = 1'b1;
            state_nx = S_HOLD;
          end
        end else begin
          short_evt = 1'b1;
          cnt_nx    = '0;
          state_nx  = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!idct_done) begin
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_WAIT;
      end
    endcase
  end

  // pixel extraction: negative clamps to 0, anything above the field clamps to 255
  always_comb begin
    pix_sat = idct_dout[PIX_LSB+7:PIX_LSB];
    if (idct_dout[BitWidth])                     pix_sat = 8'd0;
    else if (|idct_dout[BitWidth-1:PIX_LSB+8])   pix_sat = 8'd255;
  end
  assign unused_lsbs = ^idct_dout[PIX_LSB-1:0];

  // |pix - ref| squared equals the signed 9-bit difference squared
  assign abs_d   = (pix_out >= s1_ref) ? (pix_out - s1_ref) : (s1_ref - pix_out);
  assign sq_c    = {8'd0, abs_d} * {8'd0, abs_d};
  // first sample of a block restarts the accumulator, so no clear bubble is needed
  assign acc_sum = (s2_first ? 22'd0 : blk_acc) + {6'd0, s2_sq};

  // stage 1: register saturated pixel and its reference; sticky capture errors
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      s1_ref    <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      err_unf   <= 1'b0;
      err_short <= 1'b0;
    end else begin
      pix_valid <= capture;
      s1_first  <= capture && (state == S_WAIT);
      s1_last   <= blk_last;
      if (capture) begin
        pix_out <= pix_sat;
        s1_ref  <= ref_head;
      end
      if (capture && fifo_empty) err_unf <= 1'b1;
      if (short_evt)             err_short <= 1'b1;
    end
  end

  // stage 2: register the squared error
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sq    <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= pix_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      if (pix_valid) s2_sq <= sq_c;
    end
  end

  // stage 3: accumulate; a block commits to the totals only on its last sample
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_acc   <= '0;
      blk_sse   <= '0;
      blk_valid <= 1'b0;
      tot_sse   <= '0;
      blk_count <= '0;
    end else begin
      blk_valid <= s2_valid & s2_last;
      if (s2_valid) blk_acc <= acc_sum;
      if (s2_valid && s2_last) begin
        blk_sse   <= acc_sum;
        blk_count <= blk_count + 1'b1;
        tot_sse   <= tot_sse + {26'd0, acc_sum};
      end
    end
  end

endmodule
